inst_rom_loader: RTL and testbench

//  Program-download initiator for the instruction ROM write port.
//  - Takes a byte stream (UART RX or debug link) and packs bytes little-endian into 32-bit words.
//  - Writes the words to consecutive ROM word addresses through the addr/wr_data/wr_en port.
//  - Holds the core in reset (cpu_hold_o) until the image is fully written.

---
 rtl/inst_rom_loader.sv | 212 +++++++++++++++++++++
 tb/tb_inst_rom_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Program-download initiator for the instruction ROM write port.
// Packs a little-endian byte stream (4-byte word-count header followed by
// the payload) into 32-bit words. Each word is written to consecutive ROM
// word addresses starting at BASE_ADDR. The core is held in reset while
// the image is being loaded.
//
// Optional feature: define LOADER_READBACK_VERIFY_EN to read back every
// written word for one cycle and go to the error state on a mismatch.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_start_i    start pulse (honoured in IDLE/DONE/ERR)
//   load_abort_i    return to IDLE from any state; highest priority
//   byte_valid_i    stream byte valid
//   byte_data_i     stream byte
//   byte_ready_o    byte accepted when valid & ready
//   rom_addr_o      ROM byte address
//   rom_wr_data_o   ROM write word
//   rom_wr_en_o     single-cycle write strobe
//   rom_rd_data_i   ROM read data at rom_addr_o (readback only)
//   cpu_hold_o      holds the core in reset
//   load_done_o     image written (level)
//   load_err_o      load failed (level)
module inst_rom_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start_i,
  input  logic        load_abort_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_wr_data_o,
  output logic        rom_wr_en_o,
  input  logic [31:0] rom_rd_data_i,
  output logic        cpu_hold_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
`ifdef LOADER_READBACK_VERIFY_EN
    S_VERIFY = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   n_q, n_d;
  logic [WORD_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer_c;
  logic [WORD_W-1:0]   n_ins_c;
  logic [WORD_W-1:0]   shreg_ins_c;

`ifndef LOADER_READBACK_VERIFY_EN
  // Read data only matters for readback.
  logic unused_rd_c;
  assign unused_rd_c = ^rom_rd_data_i;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      addr_q    <= BASE_ADDR;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;

    xfer_c = byte_valid_i & ready_q;

    // Byte k of a word lands in bits [8k+7:8k].
    n_ins_c     = n_q;
    n_ins_c[{cnt_q, 3'b000} +: 8] = byte_data_i;
    shreg_ins_c = shreg_q;
    shreg_ins_c[{cnt_q, 3'b000} +: 8] = byte_data_i;

    if (load_abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      addr_d  = BASE_ADDR;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_start_i) begin
            state_d = S_HDR;
            cnt_d   = '0;
            idx_d   = '0;
            n_d     = '0;
            addr_d  = BASE_ADDR;
          end
        end
        S_HDR: begin
          if (xfer_c) begin
            n_d   = n_ins_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(3)) begin
              if (n_ins_c == '0) begin
                state_d = S_DONE;
              end else if (n_ins_c > WORD_W'(DEPTH_WORDS)) begin
                state_d = S_ERR;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer_c) begin
            shreg_d = shreg_ins_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(3)) begin
              state_d   = S_WRITE;
              wr_data_d = shreg_ins_c;
            end
          end
        end
        S_WRITE: begin
          idx_d = idx_q + WORD_W'(1);
`ifdef LOADER_READBACK_VERIFY_EN
          state_d = S_VERIFY;
`else
          addr_d  = addr_q + WORD_W'(4);
          state_d = (idx_q + WORD_W'(1) == n_q) ? S_DONE : S_DATA;
`endif
        end
`ifdef LOADER_READBACK_VERIFY_EN
        // Address still points at the word just written; idx already advanced.
        S_VERIFY: begin
          if (rom_rd_data_i != wr_data_q) begin
            state_d = S_ERR;
          end else begin
            addr_d  = addr_q + WORD_W'(4);
            state_d = (idx_q == n_q) ? S_DONE : S_DATA;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered copies of the decode of the next state.
    ready_d = (state_d == S_HDR) || (state_d == S_DATA);
    wr_en_d = (state_d == S_WRITE);
    hold_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  assign byte_ready_o  = ready_q;
  assign rom_addr_o    = addr_q;
  assign rom_wr_data_o = wr_data_q;
  assign rom_wr_en_o   = wr_en_q;
  assign cpu_hold_o    = hold_q;
  assign load_done_o   = done_q;
  assign load_err_o    = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: expected ROM writes are queued by the
// stimulus, a forked monitor pops and compares them on every write strobe.
module tb_inst_rom_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start_i;
  logic        load_abort_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_wr_data_o;
  logic        rom_wr_en_o;
  logic [31:0] rom_rd_data_i;
  logic        cpu_hold_o;
  logic        load_done_o;
  logic        load_err_o;

  inst_rom_loader #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH_WORDS(4096)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start_i (load_start_i),
    .load_abort_i (load_abort_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .rom_addr_o   (rom_addr_o),
    .rom_wr_data_o(rom_wr_data_o),
    .rom_wr_en_o  (rom_wr_en_o),
    .rom_rd_data_i(rom_rd_data_i),
    .cpu_hold_o   (cpu_hold_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model; optional corruption of bit 0 when reading word index 1.
  logic [31:0] rom [0:15];
  logic        corrupt;
  always @(posedge clk) begin
    if (rom_wr_en_o) rom[rom_addr_o[5:2]] <= rom_wr_data_o;
  end
  always_comb begin
    rom_rd_data_i = rom[rom_addr_o[5:2]];
    if (corrupt && rom_addr_o[5:2] == 4'd1) rom_rd_data_i[0] = ~rom_rd_data_i[0];
  end

  int          checks;
  int          failures;
  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Offer one byte from a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = byte_ready_o;
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic pulse_start();
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
  endtask

  // Send the queued stream; optional random gaps and a start pulse before byte start_at.
  task automatic run_stream(input int max_gap, input int start_at);
    int i;
    i = 0;
    while (stream.size() > 0) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      if (i == start_at) pulse_start();
      send_byte(stream.pop_front());
      i++;
    end
  endtask

  task automatic wait_end();
    for (int t = 0; t < 500 && !(load_done_o || load_err_o); t++) @(negedge clk);
    chk("end_reached", 32'(load_done_o | load_err_o), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    corrupt = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rst_n = 1'b0;
    load_start_i = 1'b0;
    load_abort_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;

    // Scoreboard monitor: every write strobe must match the next queued write.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && rom_wr_en_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", rom_addr_o, 32'hFFFF_FFFF);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("write_addr", rom_addr_o, e[63:32]);
            chk("write_data", rom_wr_data_o, e[31:0]);
          end
        end
      end
    join_none

    // 1: reset values
    idle(3);
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    chk("rst_hold", 32'(cpu_hold_o), 32'd0);
    chk("rst_addr", rom_addr_o, 32'h0);
    chk("rst_wr_en", 32'(rom_wr_en_o), 32'd0);
    chk("rst_done", 32'(load_done_o), 32'd0);
    chk("rst_err", 32'(load_err_o), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 2: two-word image, gap-free
    pulse_start();
    chk("t2_hold_after_start", 32'(cpu_hold_o), 32'd1);
    chk("t2_ready_in_hdr", 32'(byte_ready_o), 32'd1);
    push_exp(32'h0, 32'h0000_0513);
    push_exp(32'h4, 32'h0010_0593);
    push_word(32'h0000_0002);
    push_word(32'h0000_0513);
    run_stream(0, -1);
    chk("t2_wr_latency", 32'(rom_wr_en_o), 32'd1);
    chk("t2_ready_in_write", 32'(byte_ready_o), 32'd0);
    push_word(32'h0010_0593);
    run_stream(0, -1);
    wait_end();
    chk("t2_done", 32'(load_done_o), 32'd1);
    chk("t2_err", 32'(load_err_o), 32'd0);
    chk("t2_hold", 32'(cpu_hold_o), 32'd0);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);

    // 3a: empty image
    pulse_start();
    chk("t3a_done_cleared", 32'(load_done_o), 32'd0);
    push_word(32'h0000_0000);
    run_stream(0, -1);
    wait_end();
    chk("t3a_done", 32'(load_done_o), 32'd1);
    chk("t3a_hold", 32'(cpu_hold_o), 32'd0);
    idle(4);

    // 3b: oversized image
    pulse_start();
    push_word(32'd4097);
    run_stream(0, -1);
    wait_end();
    chk("t3b_err", 32'(load_err_o), 32'd1);
    chk("t3b_done", 32'(load_done_o), 32'd0);
    chk("t3b_hold", 32'(cpu_hold_o), 32'd1);
    chk("t3b_ready", 32'(byte_ready_o), 32'd0);
    idle(4);
    chk("t3b_err_sticky", 32'(load_err_o), 32'd1);

    // 4: three words with random gaps, start pulse mid-DATA (before byte 6)
    pulse_start();
    chk("t4_err_cleared", 32'(load_err_o), 32'd0);
    push_exp(32'h0, 32'hDEAD_BEEF);
    push_exp(32'h4, 32'h0000_0513);
    push_exp(32'h8, 32'h1234_5678);
    push_word(32'h0000_0003);
    push_word(32'hDEAD_BEEF);
    push_word(32'h0000_0513);
    push_word(32'h1234_5678);
    run_stream(3, 6);
    wait_end();
    chk("t4_done", 32'(load_done_o), 32'd1);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // 5: abort after the 2nd payload byte, then fresh load from base
    pulse_start();
    push_word(32'h0000_0002);
    stream.push_back(8'hAA);
    stream.push_back(8'hBB);
    run_stream(0, -1);
    load_abort_i = 1'b1;
    @(negedge clk);
    load_abort_i = 1'b0;
    chk("t5_hold", 32'(cpu_hold_o), 32'd0);
    chk("t5_ready", 32'(byte_ready_o), 32'd0);
    chk("t5_done", 32'(load_done_o), 32'd0);
    chk("t5_err", 32'(load_err_o), 32'd0);
    idle(10);
    pulse_start();
    push_exp(32'h0, 32'hCAFE_F00D);
    push_word(32'h0000_0001);
    push_word(32'hCAFE_F00D);
    run_stream(0, -1);
    wait_end();
    chk("t5_restart_done", 32'(load_done_o), 32'd1);
    chk("t5_pending", 32'(exp_q.size()), 32'd0);

    // 6: ROM corrupts word 1 on readback
    corrupt = 1'b1;
    pulse_start();
    push_exp(32'h0, 32'h1111_1111);
    push_exp(32'h4, 32'h2222_2222);
    push_word(32'h0000_0003);
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
`ifdef LOADER_READBACK_VERIFY_EN
    run_stream(0, -1);
    wait_end();
    chk("t6_err", 32'(load_err_o), 32'd1);
    chk("t6_hold", 32'(cpu_hold_o), 32'd1);
    chk("t6_done", 32'(load_done_o), 32'd0);
`else
    push_exp(32'h8, 32'h3333_3333);
    push_word(32'h3333_3333);
    run_stream(0, -1);
    wait_end();
    chk("t6_done", 32'(load_done_o), 32'd1);
    chk("t6_err", 32'(load_err_o), 32'd0);
`endif
    idle(10);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
